nibble_serial_adder: RTL

//  Multi-nibble add/subtract engine built around one addfourbit instance
//  (r1, r2, ci -> result, carry). Streams WIDTH-bit operands through the 4-bit

---
 rtl/nibble_serial_adder.sv | 108 ++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-nibble add/subtract engine: streams WIDTH-bit operands through one
// 4-bit adder, LSB nibble first, with the carry registered between nibbles.

module addfourbit (
  input  logic [3:0] r1,
  input  logic [3:0] r2,
  input  logic       ci,
  output logic [3:0] result,
  output logic       carry
);
  assign {carry, result} = 5'(r1) + 5'(r2) + 5'(ci);
endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c_reg;
  logic [IW-1:0]    idx;
  logic             a_msb, beff_msb;
  logic             accept, last;
  logic [3:0]       r1, r2, result;
  logic             ci, carry;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (idx == LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Adder sees zeros outside RUN so it does not toggle on stale shift data.
  assign r1 = (state == RUN) ? a_sh[3:0] : '0;
  assign r2 = (state == RUN) ? b_sh[3:0] : '0;
  assign ci = (state == RUN) ? c_reg     : 1'b0;

  addfourbit u_add (
    .r1     (r1),
    .r2     (r2),
    .ci     (ci),
    .result (result),
    .carry  (carry)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last)   state_next = DONE;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      c_reg    <= 1'b0;
      idx      <= '0;
      a_msb    <= 1'b0;
      beff_msb <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh     <= a;
        b_sh     <= sub ? ~b : b;
        c_reg    <= sub ? 1'b1 : cin;
        idx      <= '0;
        a_msb    <= a[WIDTH-1];
        beff_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (state == RUN) begin
        sum   <= {result, sum[WIDTH-1:4]};
        a_sh  <= {4'b0000, a_sh[WIDTH-1:4]};
        b_sh  <= {4'b0000, b_sh[WIDTH-1:4]};
        c_reg <= carry;
        idx   <= idx + 1'b1;
        // Flags are captured from the final nibble so they hold through IDLE.
        if (last) begin
          cout <= carry;
          ovf  <= (a_msb == beff_msb) && (result[3] != a_msb);
        end
      end
    end
  end
endmodule
